// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file: clear-FSM state codes and CPU default widths.
package regfile_pkg;
  localparam logic RF_IDLE  = 1'b0;
  localparam logic RF_CLEAR = 1'b1;
  localparam int   RF_DATA_W = 16;
  localparam int   RF_ADDR_W = 5;
endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks clr_idx over every entry once per clear request, reporting busy and
// the write-enable/index the storage array uses to zero entries.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_start,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == RF_IDLE) begin
      if (clr_req) begin
        state_d = RF_CLEAR;
        idx_d   = '0;
      end
    end else begin
      idx_d = idx_q + 1'b1;
      if (idx_q == {ADDR_W{1'b1}}) state_d = RF_IDLE;
    end
  end

  // clr_start marks the edge that (re)starts a clear: Reset anywhere, clr_req only from IDLE.
  always_comb begin
    clr_busy  = (state_q == RF_CLEAR);
    clr_en    = clr_busy & ~Reset;
    clr_start = Reset | ((state_q == RF_IDLE) & clr_req);
    clr_idx   = idx_q;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with sequenced clear, pending scoreboard bits and NUM_RD read ports.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_rej,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              wr_rej_q, wr_rej_d;
  logic              clr_start, clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_acc, iss_acc;

  function automatic logic is_zreg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk      (clk),
    .Reset    (Reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_start(clr_start),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  // A starting clear outranks any write or issue presented on the same edge.
  always_comb begin
    wr_acc   = wr_en & ~clr_busy & ~clr_start & ~is_zreg(wr_addr);
    iss_acc  = iss_en & ~clr_busy & ~clr_start & ~is_zreg(iss_addr);
    wr_rej_d = clr_busy & wr_en;
    pend_d   = pend_q;
    if (wr_acc)  pend_d[wr_addr]  = 1'b0;
    if (iss_acc) pend_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_start) begin
      pend_q   <= '0;
      wr_rej_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wr_rej_q <= wr_rej_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en)      mem_q[clr_idx] <= '0;
    else if (wr_acc) mem_q[wr_addr] <= wr_data;
  end

  assign wr_rej = wr_rej_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              pd;

    assign a = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      d  = mem_q[a];
      pd = pend_q[a];
      if (is_zreg(a)) begin
        d  = '0;
        pd = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_en && !clr_busy && (a == wr_addr)) begin
        d  = wr_data;
        pd = 1'b0;
      end
`endif
      if (clr_busy) d = '0;
    end

    assign rd_data[p*DATA_W +: DATA_W] = d;
    assign rd_pend[p]                  = pd;
  end

endmodule
